decode_stage: RTL and testbench
===============================

# decode_stage

Registered RV32I instruction-decode stage: accepts a fetched instruction and PC over a valid/ready handshake and decodes it. Produces a full set of datapath controls, register indices and a sign-extended XLEN immediate (I/S/B/U/J formats) in one pipeline register. Sits between fetch and execute, replacing the combinational control decoder. Adds backpressure, load-use bubble insertion, branch flush and illegal-instruction flagging.

## Interface
- XLEN, 32: datapath/immediate/PC width (32 or 64).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage accepts instruction this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  execute redirect; kill held and incoming instruction.
- out_valid  out  1  decoded instruction present.
- out_ready  in  1  execute accepts.
- out_pc  out  XLEN  PC of decoded instruction.
- out_rs1, out_rs2, out_rd  out  5 each  register indices (0 when unused).
- out_imm  out  XLEN  sign-extended immediate.
- out_alu_mode  out  5  {mext, funct3, alt}.
- out_ram_mode  out  4  {funct3, store}; 0 for non-memory.
- out_a_sel  out  1  0=rs1, 1=PC.
- out_b_sel  out  1  0=rs2, 1=imm.
- out_wb_sel  out  2  0=ALU, 1=memory, 2=PC+4.
- out_reg_we  out  1  register write enable (forced 0 when rd=0).
- out_mem_en  out  1  load or store.
- out_branch, out_jump  out  1 each  conditional branch / JAL-JALR.
- out_illegal  out  1  unsupported opcode/funct.

## Operation
- Opcodes: R (0110011), I-arith (0010011), load (0000011), store (0100011), branch (1100011), JAL, JALR, LUI, AUIPC; anything else sets out_illegal=1, reg_we=0, mem_en=0.
- alt bit = inst[30] for R-type and for I-arith only when funct3=101; otherwise 0. Loads/stores/AUIPC/JAL/JALR: alu_mode=0 (ADD). LUI: a_sel=0, rs1=0, alu ADD. Branch: alu_mode={0,funct3,0}; execute resolves using eq/lt.
- Immediates sign-extended from inst[31] to XLEN; B/J immediates have bit0=0; U = inst[31:12]<<12, sign-extended.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Load-use: on an out transfer of a load with rd!=0, capture load_rd. Next cycle hazard=1 if incoming instruction reads rs1 or rs2 (per format) equal to load_rd. Then in_ready=0 and out_valid=0 (one bubble). load_rd clears after one cycle regardless.
- Flush: next cycle out_valid=0, load_rd=0; incoming instruction not accepted.

## Timing
- Latency 1 cycle, in transfer to out_valid. Throughput 1/cycle without stalls.
- Outputs held stable while out_valid && !out_ready.
- Reset: out_valid=0, all out_* fields 0, load_rd=0; in_ready=1 after reset deasserts.
- Flush concurrent with out_ready: flush wins, instruction dropped.
- Flush during hazard: bubble cancelled, load_rd cleared.

## Configuration
- DECODE_MEXT_EN defined: R-type with funct7=0000001 decodes as M-extension, alu_mode[4]=1, not illegal.
- Undefined: such encodings set out_illegal=1 and alu_mode[4] is always 0.

## Structure
- Shared package `cpu_pkg`: opcode constants, wb_sel encodings, imm format enum (I/S/B/U/J), alu_mode field layout.
- One sub-module `imm_gen` (combinational: inst, format -> XLEN immediate). Decode table, hazard and pipeline register live in decode_stage.

## Test plan
- `add x3,x1,x2` (0x002081B3), out_ready=1 -> next cycle out_valid=1, rs1=1, rs2=2, rd=3, alu_mode=0, b_sel=0, reg_we=1.
- `addi x5,x0,-1` (0xFFF00293) -> imm=0xFFFFFFFF, b_sel=1, alt=0; `srai` with inst[30]=1 -> alt=1.
- `lw x6,0(x1)` then `add x7,x6,x0` back-to-back -> exactly one bubble cycle (out_valid=0, in_ready=0), then the add issues.
- out_ready=0 for 3 cycles with a valid instruction -> outputs stable, in_ready=0; release -> next instruction accepted same cycle.
- flush asserted while a beq is held -> next cycle out_valid=0; the instruction presented during flush is not accepted.
- Opcode 0x7F -> out_illegal=1, reg_we=0; `mul` (funct7=1) -> illegal without DECODE_MEXT_EN, alu_mode[4]=1 with it.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, write-back select codes,
// immediate format enum and the alu_mode field layout used by decode_stage.
package cpu_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    // alu_mode = {mext, funct3, alt}
    typedef struct packed {
        logic       mext;
        logic [2:0] funct3;
        logic       alt;
    } alu_mode_t;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        alu_mode_t  alu_mode;
        logic [3:0] ram_mode;
        logic       a_sel;
        logic       b_sel;
        logic [1:0] wb_sel;
        logic       reg_we;
        logic       mem_en;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

    function automatic alu_mode_t alu_mode_pack(input logic mext, input logic [2:0] funct3,
                                                input logic alt);
        alu_mode_t m;
        m.mext   = mext;
        m.funct3 = funct3;
        m.alt    = alt;
        return m;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side bus of decode_stage; the stage uses the slave modport.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    // Both sides use valid/ready: a beat moves on a cycle where valid && ready are both 1;
    // valid may not depend on ready, and the producer holds its payload until the beat moves.
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;
    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_alu_mode;
    logic [3:0]      out_ram_mode;
    logic            out_a_sel;
    logic            out_b_sel;
    logic [1:0]      out_wb_sel;
    logic            out_reg_we;
    logic            out_mem_en;
    logic            out_branch;
    logic            out_jump;
    logic            out_illegal;

    modport master (
        output in_valid, in_inst, in_pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_alu_mode, out_ram_mode, out_a_sel, out_b_sel, out_wb_sel,
               out_reg_we, out_mem_en, out_branch, out_jump, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm,
               out_alu_mode, out_ram_mode, out_a_sel, out_b_sel, out_wb_sel,
               out_reg_we, out_mem_en, out_branch, out_jump, out_illegal
    );
endinterface

// File: rtl/decode_stage_imm_gen.sv
// imm_gen: expands the I/S/B/U/J immediate field of an instruction into a
// sign-extended XLEN value (combinational).
module imm_gen
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]     i_inst,
    input  imm_fmt_e        i_fmt,
    output logic [XLEN-1:0] o_imm
);
    logic signed [11:0] w_imm_i;
    logic signed [11:0] w_imm_s;
    logic signed [12:0] w_imm_b;
    logic signed [31:0] w_imm_u;
    logic signed [20:0] w_imm_j;

    assign w_imm_i = i_inst[31:20];
    assign w_imm_s = {i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
    assign w_imm_u = {i_inst[31:12], 12'h000};
    assign w_imm_j = {i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

    // Size casts of signed operands replicate inst[31] up to XLEN.
    always_comb begin
        case (i_fmt)
            IMM_I:   o_imm = XLEN'(w_imm_i);
            IMM_S:   o_imm = XLEN'(w_imm_s);
            IMM_B:   o_imm = XLEN'(w_imm_b);
            IMM_U:   o_imm = XLEN'(w_imm_u);
            IMM_J:   o_imm = XLEN'(w_imm_j);
            default: o_imm = '0;
        endcase
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I decode between fetch and execute with load-use bubble,
// flush and illegal flagging. Define DECODE_MEXT_EN to decode M-extension R-type ops.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    logic [31:0]     w_inst;
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [6:0]      w_shift_f7;
    ctrl_t           w_ctrl;
    imm_fmt_e        w_fmt;
    logic            w_use_imm;
    logic            w_legal;
    logic [XLEN-1:0] w_gen_imm;
    logic [XLEN-1:0] w_imm;
    logic            w_hazard;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_load_leaving;

    logic            r_valid;
    ctrl_t           r_ctrl;
    logic [XLEN-1:0] r_imm;
    logic [XLEN-1:0] r_pc;
    logic [4:0]      r_load_rd;

    assign w_inst     = bus.in_inst;
    assign w_opcode   = w_inst[6:0];
    assign w_funct3   = w_inst[14:12];
    assign w_funct7   = w_inst[31:25];
    // RV64 shift amounts reach into inst[25], so that bit is not part of the funct check.
    assign w_shift_f7 = (XLEN == 64) ? {w_inst[31:26], 1'b0} : w_inst[31:25];

    always_comb begin
        w_ctrl    = '0;
        w_fmt     = IMM_I;
        w_use_imm = 1'b0;
        w_legal   = 1'b1;
        case (w_opcode)
            OP_R: begin
                w_ctrl.rs1      = w_inst[19:15];
                w_ctrl.rs2      = w_inst[24:20];
                w_ctrl.rd       = w_inst[11:7];
                w_ctrl.reg_we   = 1'b1;
                w_ctrl.alu_mode = alu_mode_pack(1'b0, w_funct3, w_inst[30]);
                case (w_funct7)
                    7'b0000000: w_legal = 1'b1;
                    7'b0100000: w_legal = (w_funct3 == 3'b000) || (w_funct3 == 3'b101);
`ifdef DECODE_MEXT_EN
                    7'b0000001: w_ctrl.alu_mode = alu_mode_pack(1'b1, w_funct3, 1'b0);
`endif
                    default:    w_legal = 1'b0;
                endcase
            end
            OP_IMM: begin
                w_ctrl.rs1      = w_inst[19:15];
                w_ctrl.rd       = w_inst[11:7];
                w_ctrl.reg_we   = 1'b1;
                w_ctrl.b_sel    = 1'b1;
                w_use_imm       = 1'b1;
                w_ctrl.alu_mode = alu_mode_pack(1'b0, w_funct3,
                                                (w_funct3 == 3'b101) && w_inst[30]);
                if (w_funct3 == 3'b001)
                    w_legal = (w_shift_f7 == 7'b0000000);
                else if (w_funct3 == 3'b101)
                    w_legal = (w_shift_f7 == 7'b0000000) || (w_shift_f7 == 7'b0100000);
            end
            OP_LOAD: begin
                w_ctrl.rs1      = w_inst[19:15];
                w_ctrl.rd       = w_inst[11:7];
                w_ctrl.reg_we   = 1'b1;
                w_ctrl.b_sel    = 1'b1;
                w_ctrl.wb_sel   = WB_MEM;
                w_ctrl.mem_en   = 1'b1;
                w_ctrl.ram_mode = {w_funct3, 1'b0};
                w_use_imm       = 1'b1;
                w_legal = (w_funct3 != 3'b111) &&
                          ((XLEN == 64) || ((w_funct3 != 3'b011) && (w_funct3 != 3'b110)));
            end
            OP_STORE: begin
                w_ctrl.rs1      = w_inst[19:15];
                w_ctrl.rs2      = w_inst[24:20];
                w_ctrl.b_sel    = 1'b1;
                w_ctrl.mem_en   = 1'b1;
                w_ctrl.ram_mode = {w_funct3, 1'b1};
                w_fmt           = IMM_S;
                w_use_imm       = 1'b1;
                w_legal = (w_funct3 <= 3'b010) || ((XLEN == 64) && (w_funct3 == 3'b011));
            end
            OP_BRANCH: begin
                w_ctrl.rs1      = w_inst[19:15];
                w_ctrl.rs2      = w_inst[24:20];
                w_ctrl.branch   = 1'b1;
                w_ctrl.alu_mode = alu_mode_pack(1'b0, w_funct3, 1'b0);
                w_fmt           = IMM_B;
                w_use_imm       = 1'b1;
                w_legal = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
            end
            OP_JAL: begin
                w_ctrl.rd     = w_inst[11:7];
                w_ctrl.reg_we = 1'b1;
                w_ctrl.a_sel  = 1'b1;
                w_ctrl.b_sel  = 1'b1;
                w_ctrl.jump   = 1'b1;
                w_ctrl.wb_sel = WB_PC4;
                w_fmt         = IMM_J;
                w_use_imm     = 1'b1;
            end
            OP_JALR: begin
                w_ctrl.rs1    = w_inst[19:15];
                w_ctrl.rd     = w_inst[11:7];
                w_ctrl.reg_we = 1'b1;
                w_ctrl.b_sel  = 1'b1;
                w_ctrl.jump   = 1'b1;
                w_ctrl.wb_sel = WB_PC4;
                w_use_imm     = 1'b1;
                w_legal       = (w_funct3 == 3'b000);
            end
            OP_LUI, OP_AUIPC: begin
                w_ctrl.rd     = w_inst[11:7];
                w_ctrl.reg_we = 1'b1;
                w_ctrl.a_sel  = (w_opcode == OP_AUIPC);
                w_ctrl.b_sel  = 1'b1;
                w_fmt         = IMM_U;
                w_use_imm     = 1'b1;
            end
            default: w_legal = 1'b0;
        endcase
        if (!w_legal) begin
            w_ctrl         = '0;
            w_ctrl.illegal = 1'b1;
            w_use_imm      = 1'b0;
        end
        w_ctrl.reg_we = w_ctrl.reg_we && (w_ctrl.rd != 5'd0);
    end

    imm_gen #(
        .XLEN(XLEN)
    ) u_imm_gen (
        .i_inst(w_inst[31:7]),
        .i_fmt (w_fmt),
        .o_imm (w_gen_imm)
    );

    assign w_imm = w_use_imm ? w_gen_imm : '0;

    // Unused source fields decode to 0, so a non-zero load_rd only matches real reads.
    assign w_hazard       = (r_load_rd != 5'd0) &&
                            ((w_ctrl.rs1 == r_load_rd) || (w_ctrl.rs2 == r_load_rd));
    assign bus.in_ready   = !bus.flush && !w_hazard && (!r_valid || bus.out_ready);
    assign w_in_fire      = bus.in_valid && bus.in_ready;
    assign w_out_fire     = r_valid && bus.out_ready;
    assign w_load_leaving = w_out_fire && !bus.flush && r_ctrl.mem_en && !r_ctrl.ram_mode[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_imm     <= '0;
            r_pc      <= '0;
            r_load_rd <= 5'd0;
        end else begin
            r_load_rd <= w_load_leaving ? r_ctrl.rd : 5'd0;
            if (bus.flush) begin
                r_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_valid <= 1'b1;
                r_ctrl  <= w_ctrl;
                r_imm   <= w_imm;
                r_pc    <= bus.in_pc;
            end else if (w_out_fire) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid    = r_valid;
    assign bus.out_pc       = r_pc;
    assign bus.out_rs1      = r_ctrl.rs1;
    assign bus.out_rs2      = r_ctrl.rs2;
    assign bus.out_rd       = r_ctrl.rd;
    assign bus.out_imm      = r_imm;
    assign bus.out_alu_mode = r_ctrl.alu_mode;
    assign bus.out_ram_mode = r_ctrl.ram_mode;
    assign bus.out_a_sel    = r_ctrl.a_sel;
    assign bus.out_b_sel    = r_ctrl.b_sel;
    assign bus.out_wb_sel   = r_ctrl.wb_sel;
    assign bus.out_reg_we   = r_ctrl.reg_we;
    assign bus.out_mem_en   = r_ctrl.mem_en;
    assign bus.out_branch   = r_ctrl.branch;
    assign bus.out_jump     = r_ctrl.jump;
    assign bus.out_illegal  = r_ctrl.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed steps followed by random traffic, all checked
// against an instruction-level reference model and a one-deep expected queue.
module tb_decode_stage;

    localparam bit MEXT =
`ifdef DECODE_MEXT_EN
        1'b1;
`else
        1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic [3:0]  ram;
        logic        a_sel;
        logic        b_sel;
        logic [1:0]  wb;
        logic        reg_we;
        logic        mem_en;
        logic        branch;
        logic        jump;
        logic        illegal;
    } exp_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;
    exp_t exp_q[$];
    logic [4:0] m_load_rd;

    decode_stage_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
        exp_t e;
        int   imm;
        logic legal;
        logic writes;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = inst[6:0];
        f3 = inst[14:12];
        f7 = inst[31:25];
        e = '0;
        imm = 0;
        legal = 1'b1;
        writes = 1'b0;
        if (op == 7'h33) begin
            e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.rd = inst[11:7]; writes = 1'b1;
            e.alu = {1'b0, f3, inst[30]};
            if (f7 == 7'h00) legal = 1'b1;
            else if (f7 == 7'h20) legal = (f3 == 3'd0) || (f3 == 3'd5);
            else if (f7 == 7'h01) begin legal = MEXT; e.alu = {1'b1, f3, 1'b0}; end
            else legal = 1'b0;
        end else if (op == 7'h13) begin
            e.rs1 = inst[19:15]; e.rd = inst[11:7]; writes = 1'b1; e.b_sel = 1'b1;
            imm = int'(inst[31:20]) - (inst[31] ? 4096 : 0);
            e.alu = {1'b0, f3, (f3 == 3'd5) ? inst[30] : 1'b0};
            if (f3 == 3'd1) legal = (f7 == 7'h00);
            if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
        end else if (op == 7'h03) begin
            e.rs1 = inst[19:15]; e.rd = inst[11:7]; writes = 1'b1; e.b_sel = 1'b1;
            e.wb = 2'd1; e.mem_en = 1'b1; e.ram = {f3, 1'b0};
            imm = int'(inst[31:20]) - (inst[31] ? 4096 : 0);
            legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        end else if (op == 7'h23) begin
            e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.b_sel = 1'b1;
            e.mem_en = 1'b1; e.ram = {f3, 1'b1};
            imm = int'({inst[31:25], inst[11:7]}) - (inst[31] ? 4096 : 0);
            legal = (f3 <= 3'd2);
        end else if (op == 7'h63) begin
            e.rs1 = inst[19:15]; e.rs2 = inst[24:20]; e.branch = 1'b1; e.alu = {1'b0, f3, 1'b0};
            imm = int'(inst[11:8]) * 2 + int'(inst[30:25]) * 32 + int'(inst[7]) * 2048
                  - int'(inst[31]) * 4096;
            legal = (f3 != 3'd2) && (f3 != 3'd3);
        end else if (op == 7'h6F) begin
            e.rd = inst[11:7]; writes = 1'b1; e.a_sel = 1'b1; e.b_sel = 1'b1;
            e.jump = 1'b1; e.wb = 2'd2;
            imm = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048 + int'(inst[19:12]) * 4096
                  - int'(inst[31]) * 1048576;
        end else if (op == 7'h67) begin
            e.rs1 = inst[19:15]; e.rd = inst[11:7]; writes = 1'b1; e.b_sel = 1'b1;
            e.jump = 1'b1; e.wb = 2'd2;
            imm = int'(inst[31:20]) - (inst[31] ? 4096 : 0);
            legal = (f3 == 3'd0);
        end else if (op == 7'h37 || op == 7'h17) begin
            e.rd = inst[11:7]; writes = 1'b1; e.b_sel = 1'b1; e.a_sel = (op == 7'h17);
            imm = int'({inst[31:12], 12'h000});
        end else begin
            legal = 1'b0;
        end
        e.imm = 32'(imm);
        e.reg_we = writes && (e.rd != 5'd0);
        if (!legal) begin
            e = '0;
            e.illegal = 1'b1;
        end
        e.pc = pc;
        return e;
    endfunction

    function automatic exp_t observed();
        exp_t o;
        o.pc = bus.out_pc;         o.rs1 = bus.out_rs1;       o.rs2 = bus.out_rs2;
        o.rd = bus.out_rd;         o.imm = bus.out_imm;       o.alu = bus.out_alu_mode;
        o.ram = bus.out_ram_mode;  o.a_sel = bus.out_a_sel;   o.b_sel = bus.out_b_sel;
        o.wb = bus.out_wb_sel;     o.reg_we = bus.out_reg_we; o.mem_en = bus.out_mem_en;
        o.branch = bus.out_branch; o.jump = bus.out_jump;     o.illegal = bus.out_illegal;
        return o;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Evaluates one cycle: compares handshake and payload, then advances the model.
    task automatic check_cycle();
        exp_t inc;
        exp_t head;
        logic m_valid;
        logic hz;
        logic exp_rdy;
        logic [4:0] nxt;
        #1;
        inc = ref_decode(bus.in_inst, bus.in_pc);
        m_valid = (exp_q.size() != 0);
        hz = (m_load_rd != 5'd0) && ((inc.rs1 == m_load_rd) || (inc.rs2 == m_load_rd));
        exp_rdy = !bus.flush && !hz && (!m_valid || bus.out_ready);
        check("out_valid", 128'(bus.out_valid), 128'(m_valid));
        check("in_ready", 128'(bus.in_ready), 128'(exp_rdy));
        nxt = 5'd0;
        if (m_valid) begin
            head = exp_q[0];
            check("fields", 128'(observed()), 128'(head));
            if (!bus.flush && bus.out_ready && head.mem_en && !head.ram[0]) nxt = head.rd;
        end
        if (bus.flush) begin
            exp_q.delete();
        end else begin
            if (m_valid && bus.out_ready) void'(exp_q.pop_front());
            if (bus.in_valid && exp_rdy) exp_q.push_back(inc);
        end
        m_load_rd = nxt;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                         input logic fl, input logic ordy);
        bus.in_valid  = v;
        bus.in_inst   = inst;
        bus.in_pc     = pc;
        bus.flush     = fl;
        bus.out_ready = ordy;
    endtask

    task automatic step();
        check_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] w;
        int k;
        w = $urandom;
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        w[11:7]  = 5'($urandom_range(0, 3));
        k = $urandom_range(0, 10);
        case (k)
            0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;
            3: w[6:0] = 7'h23;  4: w[6:0] = 7'h63;  5: w[6:0] = 7'h6F;
            6: w[6:0] = 7'h67;  7: w[6:0] = 7'h37;  8: w[6:0] = 7'h17;
            9: w[6:0] = 7'h03;
            default: w[6:0] = 7'($urandom);
        endcase
        if (w[6:0] == 7'h33 || (w[6:0] == 7'h13 && (w[14:12] == 3'd1 || w[14:12] == 3'd5))) begin
            k = $urandom_range(0, 3);
            case (k)
                0: w[31:25] = 7'h00;
                1: w[31:25] = 7'h20;
                2: w[31:25] = 7'h01;
                default: w[31:25] = 7'($urandom);
            endcase
        end
        return w;
    endfunction

    // ---------------- directed steps + random traffic ----------------
    initial begin
        n_vec = 0;
        n_miss = 0;
        m_load_rd = 5'd0;
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("reset_fields", 128'(observed()), 128'(0));
        check("reset_out_valid", 128'(bus.out_valid), 128'(0));
        rst = 1'b0;
        #1;
        check("reset_in_ready", 128'(bus.in_ready), 128'(1));
        @(negedge clk);

        // add x3,x1,x2
        drive(1'b1, 32'h002081B3, 32'h100, 1'b0, 1'b1);
        step();
        check("add_valid", 128'(bus.out_valid), 128'(1));
        check("add_rs1", 128'(bus.out_rs1), 128'(1));
        check("add_rs2", 128'(bus.out_rs2), 128'(2));
        check("add_rd", 128'(bus.out_rd), 128'(3));
        check("add_alu", 128'(bus.out_alu_mode), 128'(0));
        check("add_bsel", 128'(bus.out_b_sel), 128'(0));
        check("add_we", 128'(bus.out_reg_we), 128'(1));

        // addi x5,x0,-1 then srai x1,x2,3
        drive(1'b1, 32'hFFF00293, 32'h104, 1'b0, 1'b1);
        step();
        check("addi_imm", 128'(bus.out_imm), 128'(32'hFFFFFFFF));
        check("addi_bsel", 128'(bus.out_b_sel), 128'(1));
        check("addi_alt", 128'(bus.out_alu_mode[0]), 128'(0));
        drive(1'b1, 32'h40315093, 32'h108, 1'b0, 1'b1);
        step();
        check("srai_alu", 128'(bus.out_alu_mode), 128'(5'b01011));

        // lw x6,0(x1) leaves decode, then add x7,x6,x0 arrives
        drive(1'b1, 32'h0000A303, 32'h200, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h000303B3, 32'h204, 1'b0, 1'b1);
        #1;
        check("bubble_in_ready", 128'(bus.in_ready), 128'(0));
        check("bubble_out_valid", 128'(bus.out_valid), 128'(0));
        step();
        #1;
        check("after_bubble_in_ready", 128'(bus.in_ready), 128'(1));
        step();
        check("dep_add_issued", 128'({bus.out_valid, bus.out_rd}), 128'({1'b1, 5'd7}));

        // backpressure: hold for three cycles, then release
        drive(1'b1, 32'h00100093, 32'h300, 1'b0, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h00200113, 32'h304, 1'b0, 1'b0);
            #1;
            check("hold_in_ready", 128'(bus.in_ready), 128'(0));
            check("hold_pc", 128'(bus.out_pc), 128'(32'h300));
            step();
        end
        drive(1'b1, 32'h00200113, 32'h304, 1'b0, 1'b1);
        #1;
        check("release_in_ready", 128'(bus.in_ready), 128'(1));
        step();
        check("release_pc", 128'(bus.out_pc), 128'(32'h304));

        // flush while beq x1,x2,8 is held
        drive(1'b1, 32'h00208463, 32'h400, 1'b0, 1'b1);
        step();
        drive(1'b1, 32'h00300193, 32'h404, 1'b1, 1'b1);
        #1;
        check("flush_in_ready", 128'(bus.in_ready), 128'(0));
        step();
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        check("flush_out_valid", 128'(bus.out_valid), 128'(0));
        step();

        // illegal opcode, then mul
        drive(1'b1, 32'h0000007F, 32'h500, 1'b0, 1'b1);
        step();
        check("ill_flag", 128'(bus.out_illegal), 128'(1));
        check("ill_we", 128'(bus.out_reg_we), 128'(0));
        drive(1'b1, 32'h022081B3, 32'h504, 1'b0, 1'b1);
        step();
        check("mul_illegal", 128'(bus.out_illegal), 128'(!MEXT));
        check("mul_mext", 128'(bus.out_alu_mode[4]), 128'(MEXT));

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, rand_inst(), $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
            step();
        end

        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
